// File: rtl/q_event_monitor_pkg.sv
// Shared types and constants for the Q-state event monitor.
package common;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_TRACK = 2'd1,
    MON_STALL = 2'd2
  } monitor_states;

  typedef struct packed {
    logic [2:0]  code;
    logic [12:0] gap;
  } event_rec_t;

  localparam int unsigned GAP_MAX = 8191;
  localparam logic [2:0]  Q_DONE  = 3'b111;

endpackage

// File: rtl/q_event_monitor_fifo.sv
// Small first-word-fall-through record buffer; the head entry is presented combinationally.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/q_event_monitor.sv
// Watches the upstream sequence FSM state Q: logs transitions with inter-event gaps,
// counts completed sequences and flags a state that stays nonzero for too long.
module q_event_monitor
  import common::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [2:0]  Q,
  input  logic        clr,
  output logic [15:0] evt_data,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  done_cnt,
  output logic        stall,
  output logic        overflow
);

  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);
  localparam logic [12:0] GAP_MAX_C = 13'(GAP_MAX);

  logic [2:0]    q_prev_reg;
  logic [12:0]   gap_reg, gap_next;
  logic [11:0]   timer_reg, timer_next;
  logic [7:0]    done_cnt_reg, done_cnt_next;
  logic          overflow_reg, overflow_next;
  monitor_states state_reg, state_next;

  logic          evt_edge;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  event_rec_t    rec;

  assign evt_edge  = (Q != q_prev_reg);
  assign rec       = '{code: Q, gap: gap_reg};
  assign fifo_push = evt_edge && !clr;
  assign fifo_pop  = evt_valid && evt_ready;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(event_rec_t))
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .flush (clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rec),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    gap_next      = (gap_reg == GAP_MAX_C) ? gap_reg : gap_reg + 13'd1;
    done_cnt_next = done_cnt_reg + 8'(evt_edge && (Q == Q_DONE));
    overflow_next = overflow_reg | (fifo_push && fifo_full && !fifo_pop);
    state_next    = state_reg;
    timer_next    = timer_reg;
    if (evt_edge) gap_next = 13'd1;

    case (state_reg)
      MON_IDLE: begin
        timer_next = '0;
        if (Q != 3'b000) state_next = MON_TRACK;
      end
      MON_TRACK: begin
        if (Q == 3'b000) begin
          state_next = MON_IDLE;
          timer_next = '0;
        end else if (evt_edge) begin
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 12'd1;
          if (timer_next == TIMEOUT_C) state_next = MON_STALL;
        end
      end
      MON_STALL: begin
        if (evt_edge) begin
          timer_next = '0;
          state_next = (Q != 3'b000) ? MON_TRACK : MON_IDLE;
        end
      end
      default: begin
        state_next = MON_IDLE;
        timer_next = '0;
      end
    endcase

    // Clear overrides every update; q_prev still tracks Q so the discarded edge is not replayed.
    if (clr) begin
      gap_next      = '0;
      done_cnt_next = '0;
      overflow_next = 1'b0;
      state_next    = MON_IDLE;
      timer_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      q_prev_reg   <= 3'b000;
      gap_reg      <= '0;
      timer_reg    <= '0;
      done_cnt_reg <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= MON_IDLE;
    end else begin
      q_prev_reg   <= Q;
      gap_reg      <= gap_next;
      timer_reg    <= timer_next;
      done_cnt_reg <= done_cnt_next;
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
    end
  end

  assign evt_valid = !fifo_empty;
  assign done_cnt  = done_cnt_reg;
  assign stall     = (state_reg == MON_STALL);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_q_event_monitor.sv
// Directed bench for q_event_monitor (TIMEOUT=16, FIFO_DEPTH=4); edges counted from reset release.
module tb_q_event_monitor;
  import common::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  Q;
  logic        clr;
  logic [15:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  done_cnt;
  logic        stall;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  q_event_monitor #(.TIMEOUT(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .Q         (Q),
    .clr       (clr),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .done_cnt  (done_cnt),
    .stall     (stall),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rstN = 1'b0; Q = 3'b000; clr = 1'b0; evt_ready = 1'b1;
    step(3);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_data", 32'(evt_data), 32'h0);
    chk("rst_done", 32'(done_cnt), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    rstN = 1'b1;                                   // edge P0 just passed

    // First event at P11 carries gap 10
    step(10); Q = 3'b001;
    step(1);
    chk("t1_valid", 32'(evt_valid), 32'h1);
    chk("t1_data", 32'(evt_data), 32'h200A);
    chk("t1_done", 32'(done_cnt), 32'h0);
    step(1);
    chk("t1_popped", 32'(evt_valid), 32'h0);

    // clr coinciding with the 001->000 event
    clr = 1'b1; Q = 3'b000;
    step(1); clr = 1'b0;                           // P13
    chk("clr_valid", 32'(evt_valid), 32'h0);
    chk("clr_done", 32'(done_cnt), 32'h0);
    step(1);
    chk("clr_nospur", 32'(evt_valid), 32'h0);

    // Sequence 000->011->100->000->111->000, events 3 edges apart
    Q = 3'b011; step(1);                           // P15
    chk("s1_valid", 32'(evt_valid), 32'h1);
    chk("s1_data", 32'(evt_data), 32'h6001);
    step(2); Q = 3'b100; step(1);                  // P18
    chk("s2_data", 32'(evt_data), 32'h8003);
    step(2); Q = 3'b000; step(1);                  // P21
    chk("s3_data", 32'(evt_data), 32'h0003);
    step(2); Q = 3'b111; step(1);                  // P24
    chk("s4_data", 32'(evt_data), 32'hE003);
    step(2); Q = 3'b000; step(1);                  // P27
    chk("s5_data", 32'(evt_data), 32'h0003);
    step(1);
    chk("seq_empty", 32'(evt_valid), 32'h0);
    chk("seq_done", 32'(done_cnt), 32'h1);
    chk("seq_stall", 32'(stall), 32'h0);

    // Stall: Q held at 100 from P29, stall appears at P45
    Q = 3'b100; step(1);                           // P29
    chk("st_data", 32'(evt_data), 32'h8002);
    step(15);
    chk("st_early", 32'(stall), 32'h0);
    step(1);
    chk("st_rise", 32'(stall), 32'h1);
    step(10);
    chk("st_hold", 32'(stall), 32'h1);
    Q = 3'b000; step(1);                           // P56
    chk("st_exit", 32'(stall), 32'h0);
    chk("st_state", 32'(dut.state_reg), 32'(MON_IDLE));
    chk("st_rec", 32'(evt_data), 32'h001B);

    // Overflow: five events with no consumer
    step(1);
    chk("ov_empty", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;
    Q = 3'b001; step(1);                           // P58
    chk("ov_head", 32'(evt_data), 32'h2002);
    chk("ov_none", 32'(overflow), 32'h0);
    Q = 3'b010; step(1);
    Q = 3'b011; step(1);
    Q = 3'b100; step(1);
    chk("ov_full", 32'(overflow), 32'h0);
    Q = 3'b101; step(1);                           // dropped
    chk("ov_set", 32'(overflow), 32'h1);
    chk("ov_hold", 32'(evt_data), 32'h2002);
    Q = 3'b110; evt_ready = 1'b1; step(1);         // push with pop while full
    chk("ov_pop1", 32'(evt_data), 32'h4001);
    step(1);
    chk("ov_pop2", 32'(evt_data), 32'h6001);
    step(1);
    chk("ov_pop3", 32'(evt_data), 32'h8001);
    step(1);
    chk("ov_sixth", 32'(evt_data), 32'hC001);
    step(1);
    chk("ov_drain", 32'(evt_valid), 32'h0);
    chk("ov_sticky", 32'(overflow), 32'h1);
    clr = 1'b1; step(1); clr = 1'b0;
    chk("ov_clr", 32'(overflow), 32'h0);

    // done_cnt wrap
    for (int i = 0; i < 255; i++) begin
      Q = 3'b111; step(1);
      Q = 3'b000; step(1);
    end
    chk("wrap_255", 32'(done_cnt), 32'hFF);
    Q = 3'b111; step(1);
    chk("wrap_0", 32'(done_cnt), 32'h0);
    Q = 3'b000; step(1);

    // Gap saturation
    step(10000);
    chk("sat_empty", 32'(evt_valid), 32'h0);
    Q = 3'b001; step(1);
    chk("sat_data", 32'(evt_data), 32'h3FFF);

    // Asynchronous reset mid-sequence
    evt_ready = 1'b0;
    Q = 3'b111; step(1);
    Q = 3'b010; step(1);
    chk("pre_valid", 32'(evt_valid), 32'h1);
    chk("pre_done", 32'(done_cnt), 32'h1);
    #2; rstN = 1'b0; Q = 3'b000;
    #1;
    chk("ar_valid", 32'(evt_valid), 32'h0);
    chk("ar_data", 32'(evt_data), 32'h0);
    chk("ar_done", 32'(done_cnt), 32'h0);
    chk("ar_stall", 32'(stall), 32'h0);
    chk("ar_ovf", 32'(overflow), 32'h0);
    step(2); rstN = 1'b1;
    step(3);
    chk("ar_nospur", 32'(evt_valid), 32'h0);
    Q = 3'b101; step(1);
    chk("ar_first", 32'(evt_data), 32'hA003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_event_monitor.md
Q_EVENT_MONITOR -- requirements
Module: q_event_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of cycles a nonzero Q may stay unchanged before a stall is declared (range 2..4095).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of event records buffered (power of two).
REQ-003 SHALL have port clk, input, width 1, the single system clock, rising edge active.
REQ-004 SHALL have port rstN, input, width 1, the asynchronous active-low reset.
REQ-005 SHALL have port Q, input, width 3, the state code from the upstream sequence FSM, synchronous to clk.
REQ-006 SHALL have port clr, input, width 1, a synchronous clear of counters, flags and FIFO.
REQ-007 SHALL have port evt_data, output, width 16, the head event record {code[15:13], gap[12:0]}.
REQ-008 SHALL have port evt_valid, output, width 1, high while the FIFO is non-empty.
REQ-009 SHALL have port evt_ready, input, width 1, the consumer accept signal.
REQ-010 SHALL have port done_cnt, output, width 8, the count of completed sequences (entries into Q=3'b111).
REQ-011 SHALL have port stall, output, width 1, high while the monitor FSM is in MON_STALL.
REQ-012 SHALL have port overflow, output, width 1, a sticky flag set when an event is dropped.

Function
REQ-013 SHALL register Q into q_prev every cycle; an event SHALL be recognised at a rising edge where Q != q_prev.
REQ-014 SHALL keep a gap counter that increments every cycle, saturates at 8191, and reloads to 1 on each event edge.
REQ-015 SHALL push the record {Q, gap} at the event edge, using the gap value before its reload; the record SHALL be visible on evt_data/evt_valid one cycle after the edge.
REQ-016 SHALL pop the head record on any edge where evt_valid && evt_ready; evt_data SHALL hold its value while evt_valid is high and evt_ready is low.
REQ-017 SHALL drop a push when the FIFO is full and no pop happens in the same cycle, and SHALL set overflow, which stays set until clr or reset.
REQ-018 SHALL accept the push without overflow when the FIFO is full and a pop happens in the same cycle.
REQ-019 SHALL accept a simultaneous push and pop on an empty FIFO: the pop is ignored, the push is stored, and evt_valid is high the next cycle.
REQ-020 SHALL increment done_cnt by 1 on each event whose new Q is 3'b111, wrapping from 255 to 0.
REQ-021 SHALL implement monitor FSM states MON_IDLE, MON_TRACK and MON_STALL.
REQ-022 SHALL use these FSM transitions: MON_IDLE->MON_TRACK when Q != 0; MON_TRACK->MON_IDLE when Q == 0; MON_TRACK->MON_STALL when the stall timer reaches TIMEOUT; MON_STALL->MON_TRACK or MON_IDLE on the next event, according to the new Q.
REQ-023 SHALL clear the stall timer on every event and in MON_IDLE, increment it each cycle in MON_TRACK, and hold it in MON_STALL.
REQ-024 SHALL, on clr, flush the FIFO, zero done_cnt, overflow and the gap counter, and return the FSM to MON_IDLE; an event coinciding with clr SHALL be discarded, and clr SHALL take priority over every other update.

Reset
REQ-025 SHALL, while rstN is low, asynchronously force q_prev=3'b000, gap=0, stall timer=0, FSM=MON_IDLE, FIFO empty, evt_valid=0, evt_data=16'h0000, done_cnt=0, stall=0 and overflow=0.
REQ-026 SHALL, when reset is asserted mid-operation, lose all buffered records, and SHALL not report the upstream return to Q=000 as an event.
REQ-027 SHALL sample normally from the first rising edge after rstN deasserts.

Structure
REQ-028 SHALL place enum monitor_states {MON_IDLE, MON_TRACK, MON_STALL}, struct event_rec_t {code[2:0], gap[12:0]} and the constants GAP_MAX=8191 and Q_DONE=3'b111 in package common.
REQ-029 SHALL implement the record buffer as sub-module event_fifo (parameterised on depth and width, with push, pop, full, empty, flush); the FSM, gap counter and done counter SHALL stay in the top module.

Verification
REQ-030 SHALL cover: reset, then Q driven 000->001 at cycle 10 with evt_ready=1 -> one record {001, gap=10}, evt_valid high for 1 cycle, done_cnt=0.
REQ-031 SHALL cover: full upstream sequence 000->011->100->000->111->000 -> 5 records in order, done_cnt=1, stall=0.
REQ-032 SHALL cover: Q held at 3'b100 with TIMEOUT=16 -> stall rises 16 cycles after the event and stays high until Q changes to 000, then the FSM is in MON_IDLE.
REQ-033 SHALL cover: evt_ready=0 with 5 events -> 4 records held, overflow=1; a 6th event in the same cycle as a pop -> accepted, with no further drop.
REQ-034 SHALL cover: 256 entries into 111 -> done_cnt wraps to 0; Q held 10000 cycles -> next record gap=8191.
REQ-035 SHALL cover: clr coinciding with an event, and rstN pulsed low mid-sequence -> FIFO empty, all outputs at reset values, no spurious record afterwards.
